gba_cart_mem_arbiter: RTL and testbench

- Shares one single-port 32-bit cartridge memory between two requesters: the HPS download stream (16-bit halfwords) and GBA core cart reads (32-bit words).
- Packs halfwords into words with byte enables. Back-pressures the download through dl_wait.
- CPU reads get priority, bounded by a starvation limit for pending writes.
- Sits between hps_io/gba_top and the cart RAM, all in the clk_sys domain.

---
 rtl/gba_cart_arb_pkg.sv | 23 ++
 rtl/gba_cart_mem_arbiter_packer.sv | 119 +++++++++++
 rtl/gba_cart_mem_arbiter.sv | 111 +++++++++++
 tb/tb_gba_cart_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_cart_arb_pkg.sv
// Shared types for the cartridge memory arbiter: FSM states, byte-enable
// patterns and the packed write request handed from packer to arbiter.
package gba_cart_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   // Request address field is wide enough for any supported ADDR_W (<= 16).
   localparam int REQ_ADDR_W = 16;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic [3:0]            be;
      logic [31:0]           data;
   } wr_req_t;

endpackage

// File: rtl/gba_cart_mem_arbiter_packer.sv
// Packs download halfwords into word writes. Holds one low half (hbuf) waiting
// for its partner and one complete request (pend) waiting for the arbiter.
module gba_halfword_packer
   import gba_cart_arb_pkg::*;
#(
   parameter int ADDR_W = 13
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [24:0]   dl_addr,
   input  logic [15:0]   dl_data,
   output logic          dl_wait,
   output logic          dl_done,
   output wr_req_t       req,
   output logic          req_valid,
   input  logic          req_accept
);

   logic              hbuf_valid, hbuf_valid_n;
   logic [ADDR_W-1:0] hbuf_addr, hbuf_addr_n;
   logic [15:0]       hbuf_data, hbuf_data_n;
   logic              pend_valid, pend_valid_n;
   wr_req_t           pend, pend_n;
   logic              active_q;
   logic              flushing, flushing_n;
   logic              done_n;
   logic [ADDR_W-1:0] waddr;
   logic              wr_ok;
   logic              same_word;
   logic              unused_bits;

   assign waddr       = dl_addr[ADDR_W+1:2];
   assign wr_ok       = dl_wr && !dl_wait && (dl_addr[24:ADDR_W+2] == '0);
   assign same_word   = hbuf_valid && (hbuf_addr == waddr);
   assign req         = pend;
   assign req_valid   = pend_valid;
   assign unused_bits = dl_addr[0];

   function automatic wr_req_t mk_req(input logic [ADDR_W-1:0] a,
                                      input logic [3:0]        be,
                                      input logic [31:0]       d);
      wr_req_t r;
      r                  = '0;
      r.addr[ADDR_W-1:0] = a;
      r.be               = be;
      r.data             = d;
      return r;
   endfunction

   // Next buffer/pend state: pack the incoming halfword first, then flush.
   always_comb begin
      hbuf_valid_n = hbuf_valid;
      hbuf_addr_n  = hbuf_addr;
      hbuf_data_n  = hbuf_data;
      pend_valid_n = pend_valid && !req_accept;
      pend_n       = pend;
      flushing_n   = flushing || (active_q && !dl_active);
      done_n       = 1'b0;

      if (wr_ok) begin
         if (!dl_addr[1]) begin
            if (hbuf_valid && !same_word) begin
               pend_valid_n = 1'b1;
               pend_n       = mk_req(hbuf_addr, BE_LO, {16'h0000, hbuf_data});
            end
            hbuf_valid_n = 1'b1;
            hbuf_addr_n  = waddr;
            hbuf_data_n  = dl_data;
         end else if (same_word) begin
            pend_valid_n = 1'b1;
            pend_n       = mk_req(waddr, BE_ALL, {dl_data, hbuf_data});
            hbuf_valid_n = 1'b0;
         end else begin
            pend_valid_n = 1'b1;
            pend_n       = mk_req(waddr, BE_HI, {dl_data, 16'h0000});
         end
      end

      // An orphan low half goes out on its own once the download has ended.
      if (flushing_n && hbuf_valid_n && !pend_valid_n) begin
         pend_valid_n = 1'b1;
         pend_n       = mk_req(hbuf_addr_n, BE_LO, {16'h0000, hbuf_data_n});
         hbuf_valid_n = 1'b0;
      end

      if (flushing_n && !hbuf_valid_n && !pend_valid_n) begin
         flushing_n = 1'b0;
         done_n     = 1'b1;
      end
   end

   // Buffer, pending request and handshake registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hbuf_valid <= 1'b0;
         hbuf_addr  <= '0;
         hbuf_data  <= '0;
         pend_valid <= 1'b0;
         pend       <= '0;
         active_q   <= 1'b0;
         flushing   <= 1'b0;
         dl_wait    <= 1'b0;
         dl_done    <= 1'b0;
      end else begin
         hbuf_valid <= hbuf_valid_n;
         hbuf_addr  <= hbuf_addr_n;
         hbuf_data  <= hbuf_data_n;
         pend_valid <= pend_valid_n;
         pend       <= pend_n;
         active_q   <= dl_active;
         flushing   <= flushing_n;
         dl_wait    <= pend_valid;
         dl_done    <= done_n;
      end
   end

endmodule

// File: rtl/gba_cart_mem_arbiter.sv
// Arbitrates the single-port cart RAM between CPU reads and packed download
// writes. Reads win unless a pending write has lost STARVE_MAX times.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | grant a write (1 cycle, stay) or a read (address out now)
//   RD_WAIT | memory returns read data; capture it and pulse cpu_valid
module gba_cart_mem_arbiter
   import gba_cart_arb_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [24:0]       dl_addr,
   input  logic [15:0]       dl_data,
   output logic              dl_wait,
   output logic              dl_done,
   input  logic              cpu_rd,
   input  logic [ADDR_W+1:0] cpu_addr,
   output logic [31:0]       cpu_data,
   output logic              cpu_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int AGE_W = $clog2(STARVE_MAX + 1);

   arb_state_t       state, state_n;
   logic [AGE_W-1:0] age, age_n;
   logic             ready;
   wr_req_t          req;
   logic             req_valid;
   logic             req_accept;
   logic             unused_bits;

   assign unused_bits = ^{cpu_addr[1:0], req.addr};

   gba_halfword_packer #(
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dl_active  (dl_active),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_data    (dl_data),
      .dl_wait    (dl_wait),
      .dl_done    (dl_done),
      .req        (req),
      .req_valid  (req_valid),
      .req_accept (req_accept)
   );

   // Grant decision and memory port drive; bus idles at zero when unused.
   always_comb begin
      state_n    = state;
      age_n      = age;
      req_accept = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (ready) begin
               if (req_valid && (!cpu_rd || age == AGE_W'(STARVE_MAX))) begin
                  req_accept = 1'b1;
                  mem_we     = 1'b1;
                  mem_addr   = req.addr[ADDR_W-1:0];
                  mem_be     = req.be;
                  mem_wdata  = req.data;
                  age_n      = '0;
               end else if (cpu_rd) begin
                  mem_addr = cpu_addr[ADDR_W+1:2];
                  state_n  = RD_WAIT;
                  if (req_valid && age != AGE_W'(STARVE_MAX))
                     age_n = age + AGE_W'(1);
               end
            end
         end
         RD_WAIT: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, starvation age and registered read return.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         age       <= '0;
         ready     <= 1'b0;
         cpu_valid <= 1'b0;
         cpu_data  <= '0;
      end else begin
         state     <= state_n;
         age       <= age_n;
         ready     <= 1'b1;
         cpu_valid <= (state == RD_WAIT);
         if (state == RD_WAIT)
            cpu_data <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_gba_cart_mem_arbiter.sv
// Bench for gba_cart_mem_arbiter: directed scenarios plus a randomized
// download/read mix checked against a byte-image and read-golden model.
module tb_gba_cart_mem_arbiter;
   import gba_cart_arb_pkg::*;

   localparam int ADDR_W     = 13;
   localparam int STARVE_MAX = 8;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              dl_active = 1'b0;
   logic              dl_wr = 1'b0;
   logic [24:0]       dl_addr = '0;
   logic [15:0]       dl_data = '0;
   logic              dl_wait, dl_done;
   logic              cpu_rd = 1'b0;
   logic [ADDR_W+1:0] cpu_addr = '0;
   logic [31:0]       cpu_data;
   logic              cpu_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;

   always #5 clk_sys = ~clk_sys;

   gba_cart_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .dl_active (dl_active),
      .dl_wr     (dl_wr),
      .dl_addr   (dl_addr),
      .dl_data   (dl_data),
      .dl_wait   (dl_wait),
      .dl_done   (dl_done),
      .cpu_rd    (cpu_rd),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_valid (cpu_valid),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       data;
   } wlog_t;

   logic [31:0] ram  [DEPTH];
   logic [31:0] gold [4096];
   logic [7:0]  exp_bytes [1024];
   wlog_t       wlog [$];
   int          n_vec = 0, n_err = 0;
   int          wait_cnt = 0, done_cnt = 0;
   bit          dl_fin = 1'b0;

   // Synchronous single-port RAM model plus write/strobe logging.
   always @(posedge clk_sys) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         wlog.push_back('{mem_addr, mem_be, mem_wdata});
      end
      if (dl_wait) wait_cnt <= wait_cnt + 1;
      if (dl_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic wait_dl_ready();
      int guard = 0;
      while (dl_wait && guard < 200) begin tick(); guard++; end
      if (guard >= 200) chk("dl_wait_timeout", 32'(guard), 32'd0);
   endtask

   task automatic dl_write(input logic [24:0] a, input logic [15:0] d);
      wait_dl_ready();
      dl_addr = a; dl_data = d; dl_wr = 1'b1;
      tick();
      dl_wr = 1'b0;
      tick();
   endtask

   task automatic cpu_read(input logic [ADDR_W+1:0] a, output logic [31:0] d, output int lat);
      cpu_addr = a; cpu_rd = 1'b1; lat = 0;
      do begin tick(); lat++; end while (!cpu_valid && lat < 50);
      d = cpu_data;
      cpu_rd = 1'b0;
   endtask

   task automatic note_half(input logic [24:0] a, input logic [15:0] d);
      int ba;
      ba = int'(a[9:1]) * 2;
      exp_bytes[ba]     = d[7:0];
      exp_bytes[ba + 1] = d[15:8];
   endtask

   initial begin
      logic [31:0] d;
      int          lat, w0, d0, cnt, guard, nv;

      for (int i = 0; i < 4096; i++) begin
         gold[i] = $urandom;
         ram[4096 + i] = gold[i];
      end
      ram[8] = 32'hDEADBEEF;

      // Reset: outputs quiet even with a read request held.
      cpu_addr = 15'h0124; cpu_rd = 1'b1;
      tick(3);
      chk("rst_dl_wait", 32'(dl_wait), 0);
      chk("rst_dl_done", 32'(dl_done), 0);
      chk("rst_cpu_valid", 32'(cpu_valid), 0);
      chk("rst_cpu_data", cpu_data, 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_be", 32'(mem_be), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      cpu_rd = 1'b0;
      reset_n = 1'b1;
      tick(2);

      // Uncontested pair.
      dl_active = 1'b1;
      wlog.delete(); w0 = wait_cnt;
      dl_write(25'h10, 16'h1111);
      dl_write(25'h12, 16'h2222);
      tick(4);
      chk("pair_nwr", 32'(wlog.size()), 1);
      if (wlog.size() > 0) begin
         chk("pair_addr", 32'(wlog[0].addr), 4);
         chk("pair_be", 32'(wlog[0].be), 32'hF);
         chk("pair_wdata", wlog[0].data, 32'h22221111);
      end
      chk("pair_wait_cycles", 32'(wait_cnt - w0), 1);

      // Uncontested read.
      cpu_read(15'h20, d, lat);
      chk("rd_data", d, 32'hDEADBEEF);
      chk("rd_latency", 32'(lat), 2);

      // Starvation bound with a continuously held read.
      wlog.delete(); nv = 0; cnt = 0;
      fork
         begin
            cpu_addr = {13'h1234, 2'b00}; cpu_rd = 1'b1;
            for (int i = 0; i < 70; i++) begin
               tick();
               if (cpu_valid) begin
                  chk("starve_rdata", cpu_data, gold[13'h1234 - 4096]);
                  nv++;
               end
            end
            cpu_rd = 1'b0;
         end
         begin
            tick(4);
            dl_write(25'h100, 16'h3333);
            dl_addr = 25'h102; dl_data = 16'h4444; dl_wr = 1'b1;
            tick();
            dl_wr = 1'b0;
            guard = 0;
            while (!mem_we && guard < 100) begin
               if (mem_addr == 13'h1234) cnt++;
               tick(); guard++;
            end
            chk("starve_grants", 32'(cnt), STARVE_MAX);
            chk("starve_wr_addr", 32'(mem_addr), 32'h40);
            chk("starve_wr_be", 32'(mem_be), 32'hF);
            chk("starve_wr_data", mem_wdata, 32'h44443333);
         end
      join
      chk("starve_reads_done", 32'(nv >= 20), 1);
      tick(3);

      // Trailing odd halfword flushed at end of download.
      wlog.delete(); d0 = done_cnt;
      dl_write(25'h40, 16'hABCD);
      dl_active = 1'b0;
      tick(6);
      chk("odd_nwr", 32'(wlog.size()), 1);
      if (wlog.size() > 0) begin
         chk("odd_addr", 32'(wlog[0].addr), 32'h10);
         chk("odd_be", 32'(wlog[0].be), 32'h3);
         chk("odd_wdata_lo", 32'(wlog[0].data[15:0]), 32'hABCD);
      end
      chk("odd_done_pulses", 32'(done_cnt - d0), 1);

      // Non-contiguous low halves.
      dl_active = 1'b1; tick();
      wlog.delete();
      dl_write(25'h00, 16'h0A0A);
      dl_write(25'h08, 16'h0B0B);
      tick(4);
      chk("noncontig_nwr", 32'(wlog.size()), 1);
      if (wlog.size() > 0) begin
         chk("noncontig_addr", 32'(wlog[0].addr), 0);
         chk("noncontig_be", 32'(wlog[0].be), 32'h3);
         chk("noncontig_lo", 32'(wlog[0].data[15:0]), 32'h0A0A);
      end
      dl_active = 1'b0;
      tick(6);
      chk("noncontig_flush_nwr", 32'(wlog.size()), 2);
      if (wlog.size() > 1) chk("noncontig_flush_addr", 32'(wlog[1].addr), 2);

      // Out-of-range write dropped; done one cycle after the fall.
      dl_active = 1'b1; tick(2);
      wlog.delete();
      dl_write(25'(1) << (ADDR_W + 2), 16'h5555);
      tick(2);
      dl_active = 1'b0;
      tick();
      chk("oor_done_now", 32'(dl_done), 1);
      tick();
      chk("oor_done_once", 32'(dl_done), 0);
      tick(3);
      chk("oor_nwr", 32'(wlog.size()), 0);

      // Reset in RD_WAIT.
      cpu_addr = 15'h20; cpu_rd = 1'b1;
      tick();
      reset_n = 1'b0;
      tick();
      chk("rstrd_valid", 32'(cpu_valid), 0);
      chk("rstrd_data", cpu_data, 0);
      chk("rstrd_mem_addr", 32'(mem_addr), 0);
      chk("rstrd_mem_we", 32'(mem_we), 0);
      tick();
      chk("rstrd_valid2", 32'(cpu_valid), 0);
      cpu_rd = 1'b0; reset_n = 1'b1;
      tick(2);
      cpu_read(15'h20, d, lat);
      chk("rstrd_after_data", d, 32'hDEADBEEF);
      chk("rstrd_after_lat", 32'(lat), 2);

      // Randomized download against concurrent reads.
      for (int w = 0; w < 256; w++) begin
         ram[w] = $urandom;
         for (int b = 0; b < 4; b++) exp_bytes[4*w + b] = ram[w][8*b +: 8];
      end
      d0 = done_cnt;
      dl_active = 1'b1; tick(2);
      fork
         begin
            logic [24:0] a;
            logic [15:0] h0, h1;
            for (int i = 0; i < 150; i++) begin
               a  = 25'($urandom_range(0, 255)) << 2;
               h0 = 16'($urandom); h1 = 16'($urandom);
               case ($urandom_range(0, 3))
                  0, 1: begin
                     dl_write(a, h0); note_half(a, h0);
                     dl_write(a | 25'h2, h1); note_half(a | 25'h2, h1);
                  end
                  2: begin
                     a = a | 25'($urandom_range(0, 1) << 1);
                     dl_write(a, h0); note_half(a, h0);
                  end
                  default: dl_write(a | (25'(1) << (15 + $urandom_range(0, 9))), h0);
               endcase
            end
            wait_dl_ready();
            a  = 25'($urandom_range(0, 255)) << 2;
            h0 = 16'($urandom);
            dl_addr = a; dl_data = h0; dl_wr = 1'b1; dl_active = 1'b0;
            note_half(a, h0);
            tick();
            dl_wr = 1'b0;
            guard = 0;
            while (done_cnt == d0 && guard < 200) begin tick(); guard++; end
            tick(4);
            chk("rand_done_pulses", 32'(done_cnt - d0), 1);
            dl_fin = 1'b1;
         end
         begin
            int          wa, rl;
            logic [31:0] rd;
            while (!dl_fin) begin
               wa = $urandom_range(0, 4095);
               cpu_read(15'((4096 + wa) << 2), rd, rl);
               chk("rand_rdata", rd, gold[wa]);
               chk("rand_rd_lat_le3", 32'(rl <= 3), 1);
               tick($urandom_range(0, 2));
            end
         end
      join
      tick(4);
      for (int w = 0; w < 256; w++)
         chk("rand_image", ram[w], {exp_bytes[4*w+3], exp_bytes[4*w+2],
                                    exp_bytes[4*w+1], exp_bytes[4*w]});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
